bcd_countdown: RTL and testbench
================================

BCD_COUNTDOWN -- requirements
Module: bcd_countdown

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-002 Parameter DIGITS, default 2, SHALL set the number of cascaded BCD digits (range 1..8).
REQ-003 Port clk  input  1  SHALL be the rising-edge clock for all state.
REQ-004 Port rst_n  input  1  SHALL be the asynchronous active-low reset.
REQ-005 Port load  input  1  SHALL request loading of load_val.
REQ-006 Port load_val  input  4*DIGITS  SHALL carry the BCD start value, with digit 0 in bits [3:0].
REQ-007 Port en  input  1  SHALL be the count tick, one decrement per cycle high while running.
REQ-008 Port count  output  4*DIGITS  SHALL be the registered BCD count value.
REQ-009 Port busy  output  1  SHALL be high while in state RUN.
REQ-010 Port done  output  1  SHALL be a registered one-cycle expiry pulse.

Function
REQ-011 States SHALL be IDLE, RUN and EXPIRE; busy SHALL equal (state==RUN).
REQ-012 load SHALL have priority over en in every state.
REQ-013 On load, each load_val digit above 9 SHALL be clamped to 9; the clamped value SHALL be written to count and to an internal reload register.
REQ-014 After a load, the next state SHALL be RUN if the clamped value is nonzero, else IDLE; a load SHALL NOT assert done.
REQ-015 In RUN with en=1 and load=0, count SHALL decrement by 1 in BCD: a digit at 0 with borrow-in SHALL become 9 and propagate the borrow; other digits SHALL decrement by 1.
REQ-016 In RUN, the decrement from count==1 SHALL be the expiring tick.
REQ-017 On the expiring tick, done SHALL be 1 in the following cycle only; the Configuration section defines count and state on that tick.
REQ-018 In IDLE and EXPIRE, en SHALL be ignored and count held.
REQ-019 EXPIRE SHALL last one cycle, then go to IDLE unless load=1 (REQ-014 applies).
REQ-020 In RUN with en=0, count and state SHALL hold.
REQ-021 done SHALL be 0 in every cycle other than the one following an expiring tick.
REQ-022 Latency SHALL be one cycle from a load or en edge to the updated count.

Reset
REQ-023 rst_n=0 SHALL immediately force count=0, the reload register=0, state=IDLE, busy=0 and done=0, regardless of clk.
REQ-024 Reset asserted during RUN SHALL abort the countdown with no done pulse.
REQ-025 After rst_n deasserts, the block SHALL stay in IDLE until the first load.

Configuration
REQ-026 Macro BCD_COUNTDOWN_AUTORELOAD_EN SHALL select the expiry behaviour.
REQ-027 Without the macro, the expiring tick SHALL set count=0 and state=EXPIRE.
REQ-028 With the macro, the expiring tick SHALL set count to the reload register value and keep state=RUN (EXPIRE unused); done SHALL still pulse for one cycle.
REQ-029 With the macro, a simultaneous load SHALL override the reload and update the reload register.

Verification
REQ-030 DIGITS=2; load 0x12, en held high -> count 11,10,09,...,01,00; done=1 for exactly one cycle with count=00; then IDLE and busy=0.
REQ-031 Borrow: count 0x10 with en for one cycle -> 0x09; count 0x100 (DIGITS=3) with one en -> 0x099.
REQ-032 Clamp: load_val 0xA5 -> count 0x95; load_val 0x00 -> IDLE, busy=0, no done.
REQ-033 Priority: load=1 with load_val 0x07 and en=1 while count=0x01 -> count 0x07, no done, still RUN.
REQ-034 Reset: rst_n pulsed low between clock edges at count 0x05 -> count 0x00, busy 0 at once; no done afterwards.
REQ-035 With the macro: load 0x03, en held high -> 02,01,03,02,01,03...; done pulses with each reload and busy stays 1.

Source files
------------

// File: rtl/bcd_countdown_if.sv
// bcd_countdown_if -- control/status bundle for the bcd_countdown timer.
//   load      : request to load load_val (has priority over en)
//   load_val  : BCD start value, 4*DIGITS bits, digit 0 in [3:0]
//   en        : count tick, one decrement per cycle while running
//   count     : registered BCD count value
//   busy      : high while the counter is running
//   done      : registered one-cycle expiry pulse
// Modports: master drives the controls, slave is the counter.
interface bcd_countdown_if #(
    parameter int unsigned DIGITS = 2
);
    logic                  load;
    logic [4*DIGITS-1:0]   load_val;
    logic                  en;
    logic [4*DIGITS-1:0]   count;
    logic                  busy;
    logic                  done;

    modport master (
        output load, load_val, en,
        input  count, busy, done
    );

    modport slave (
        input  load, load_val, en,
        output count, busy, done
    );
endinterface

// File: rtl/bcd_countdown.sv
// bcd_countdown -- cascaded BCD down-counter with IDLE/RUN/EXPIRE control.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : bcd_countdown_if.slave (load, load_val, en -> count, busy, done)
// Parameter DIGITS (1..8) sets the number of BCD digits.
// Macro BCD_COUNTDOWN_AUTORELOAD_EN: on expiry, reload the last loaded value
// and keep running instead of stopping at zero.
module bcd_countdown #(
    parameter int unsigned DIGITS = 2
) (
    input logic               clk,
    input logic               rst_n,
    bcd_countdown_if.slave    bus
);
    localparam int unsigned W = 4 * DIGITS;
    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, RUN, EXPIRE} state_t;

    state_t          state, state_nxt;
    logic [W-1:0]    count_q, count_nxt;
    logic            done_q, done_nxt;
    logic [W-1:0]    load_clamped;

`ifdef BCD_COUNTDOWN_AUTORELOAD_EN
    logic [W-1:0]    reload_q, reload_nxt;
`endif

    // Any digit above 9 is forced to 9.
    function automatic logic [W-1:0] bcd_clamp(input logic [W-1:0] v);
        logic [W-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = (v[4*i +: 4] > 4'd9) ? 4'd9 : v[4*i +: 4];
        end
        return r;
    endfunction

    // BCD decrement by one: a zero digit under borrow wraps to 9 and
    // passes the borrow on.
    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         borrow;
        logic [3:0]   d;
        r      = '0;
        borrow = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            d = v[4*i +: 4];
            if (!borrow) begin
                r[4*i +: 4] = d;
            end else if (d == 4'd0) begin
                r[4*i +: 4] = 4'd9;
            end else begin
                r[4*i +: 4] = d - 4'd1;
                borrow      = 1'b0;
            end
        end
        return r;
    endfunction

    assign load_clamped = bcd_clamp(bus.load_val);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            count_q  <= '0;
            done_q   <= 1'b0;
`ifdef BCD_COUNTDOWN_AUTORELOAD_EN
            reload_q <= '0;
`endif
        end else begin
            state    <= state_nxt;
            count_q  <= count_nxt;
            done_q   <= done_nxt;
`ifdef BCD_COUNTDOWN_AUTORELOAD_EN
            reload_q <= reload_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt  = state;
        count_nxt  = count_q;
        done_nxt   = 1'b0;
`ifdef BCD_COUNTDOWN_AUTORELOAD_EN
        reload_nxt = reload_q;
`endif
        if (bus.load) begin
            count_nxt  = load_clamped;
`ifdef BCD_COUNTDOWN_AUTORELOAD_EN
            reload_nxt = load_clamped;
`endif
            state_nxt  = (load_clamped != '0) ? RUN : IDLE;
        end else begin
            unique case (state)
                IDLE: ;
                RUN: begin
                    if (bus.en) begin
                        if (count_q == ONE) begin
                            done_nxt  = 1'b1;
`ifdef BCD_COUNTDOWN_AUTORELOAD_EN
                            count_nxt = reload_q;
                            state_nxt = RUN;
`else
                            count_nxt = '0;
                            state_nxt = EXPIRE;
`endif
                        end else begin
                            count_nxt = bcd_dec(count_q);
                        end
                    end
                end
                EXPIRE: state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign bus.count = count_q;
    assign bus.busy  = (state == RUN);
    assign bus.done  = done_q;
endmodule

// File: tb/tb_bcd_countdown.sv
// tb_bcd_countdown -- directed self-checking bench for bcd_countdown.
// Drives a DIGITS=2 instance for the main scenarios and a DIGITS=3 instance
// for the multi-digit borrow. Honours BCD_COUNTDOWN_AUTORELOAD_EN.
module tb_bcd_countdown;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;

    bcd_countdown_if #(.DIGITS(2)) bus2 ();
    bcd_countdown_if #(.DIGITS(3)) bus3 ();

    bcd_countdown #(.DIGITS(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
    bcd_countdown #(.DIGITS(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] to_bcd2(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    initial begin
        n_checks      = 0;
        n_pass        = 0;
        rst_n         = 1'b0;
        bus2.load     = 1'b0;
        bus2.load_val = '0;
        bus2.en       = 1'b0;
        bus3.load     = 1'b0;
        bus3.load_val = '0;
        bus3.en       = 1'b0;

        #1;
        check("rst_count", 32'(bus2.count), 32'h00);
        check("rst_busy",  32'(bus2.busy),  32'h0);
        check("rst_done",  32'(bus2.done),  32'h0);
        #11 rst_n = 1'b1;
        tick();
        check("idle_after_rst", 32'(bus2.busy), 32'h0);

        // Load 12 with en held high and count down.
        bus2.load     = 1'b1;
        bus2.load_val = 8'h12;
        bus2.en       = 1'b1;
        tick();
        check("load12_count", 32'(bus2.count), 32'h12);
        check("load12_busy",  32'(bus2.busy),  32'h1);
        check("load12_done",  32'(bus2.done),  32'h0);
        bus2.load = 1'b0;
        for (int v = 11; v >= 1; v--) begin
            tick();
            check($sformatf("dec_%0d", v), 32'(bus2.count), 32'(to_bcd2(v)));
            check($sformatf("dec_done_%0d", v), 32'(bus2.done), 32'h0);
        end
        tick();
`ifdef BCD_COUNTDOWN_AUTORELOAD_EN
        check("exp_count", 32'(bus2.count), 32'h12);
        check("exp_done",  32'(bus2.done),  32'h1);
        check("exp_busy",  32'(bus2.busy),  32'h1);
        tick();
        check("after_exp_count", 32'(bus2.count), 32'h11);
        check("after_exp_done",  32'(bus2.done),  32'h0);
`else
        check("exp_count", 32'(bus2.count), 32'h00);
        check("exp_done",  32'(bus2.done),  32'h1);
        check("exp_busy",  32'(bus2.busy),  32'h0);
        tick();
        check("after_exp_count", 32'(bus2.count), 32'h00);
        check("after_exp_done",  32'(bus2.done),  32'h0);
        check("after_exp_busy",  32'(bus2.busy),  32'h0);
`endif
        bus2.en = 1'b0;

        // Three-digit borrow 100 -> 099.
        bus3.load     = 1'b1;
        bus3.load_val = 12'h100;
        tick();
        check("d3_load", 32'(bus3.count), 32'h100);
        bus3.load = 1'b0;
        bus3.en   = 1'b1;
        tick();
        check("d3_borrow", 32'(bus3.count), 32'h099);
        bus3.en = 1'b0;

        // Clamp and hold with en low.
        bus2.load     = 1'b1;
        bus2.load_val = 8'hA5;
        tick();
        check("clamp_A5", 32'(bus2.count), 32'h95);
        check("clamp_busy", 32'(bus2.busy), 32'h1);
        bus2.load = 1'b0;
        tick();
        check("hold_en0", 32'(bus2.count), 32'h95);
        check("hold_busy", 32'(bus2.busy), 32'h1);
        bus2.load     = 1'b1;
        bus2.load_val = 8'h5F;
        tick();
        check("clamp_5F", 32'(bus2.count), 32'h59);
        bus2.load_val = 8'h00;
        tick();
        check("zero_count", 32'(bus2.count), 32'h00);
        check("zero_busy",  32'(bus2.busy),  32'h0);
        check("zero_done",  32'(bus2.done),  32'h0);
        bus2.load = 1'b0;
        bus2.en   = 1'b1;
        tick();
        check("zero_idle_done", 32'(bus2.done), 32'h0);
        check("zero_idle_count", 32'(bus2.count), 32'h00);
        bus2.en = 1'b0;

        // Load beats en at count 01.
        bus2.load     = 1'b1;
        bus2.load_val = 8'h01;
        tick();
        check("pri_setup", 32'(bus2.count), 32'h01);
        bus2.load_val = 8'h07;
        bus2.en       = 1'b1;
        tick();
        check("pri_count", 32'(bus2.count), 32'h07);
        check("pri_done",  32'(bus2.done),  32'h0);
        check("pri_busy",  32'(bus2.busy),  32'h1);
        bus2.load = 1'b0;
        bus2.en   = 1'b0;

        // Asynchronous reset mid-cycle at count 05.
        bus2.load     = 1'b1;
        bus2.load_val = 8'h05;
        tick();
        check("rst2_setup", 32'(bus2.count), 32'h05);
        bus2.load = 1'b0;
        bus2.en   = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("arst_count", 32'(bus2.count), 32'h00);
        check("arst_busy",  32'(bus2.busy),  32'h0);
        check("arst_done",  32'(bus2.done),  32'h0);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("post_rst_done_%0d", i), 32'(bus2.done), 32'h0);
            check($sformatf("post_rst_busy_%0d", i), 32'(bus2.busy), 32'h0);
        end
        bus2.en = 1'b0;

`ifdef BCD_COUNTDOWN_AUTORELOAD_EN
        // Auto-reload: 03,02,01,03,... with done on each reload.
        bus2.load     = 1'b1;
        bus2.load_val = 8'h03;
        bus2.en       = 1'b1;
        tick();
        check("ar_load", 32'(bus2.count), 32'h03);
        bus2.load = 1'b0;
        for (int r = 0; r < 2; r++) begin
            tick();
            check("ar_02", 32'(bus2.count), 32'h02);
            check("ar_02_done", 32'(bus2.done), 32'h0);
            tick();
            check("ar_01", 32'(bus2.count), 32'h01);
            tick();
            check("ar_reload", 32'(bus2.count), 32'h03);
            check("ar_done", 32'(bus2.done), 32'h1);
            check("ar_busy", 32'(bus2.busy), 32'h1);
        end
        bus2.en = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
